jt49_bus_seq: RTL and testbench



---
 rtl/jt49_bus_seq.sv | 130 +++++++++++++
 tb/tb_jt49_bus_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_seq.sv
// jt49_bus_seq: FIFO-buffered command sequencer producing JT49 BDIR/BC1 bus cycles
module jt49_bus_seq #(
    parameter int AW   = 2,
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);
    localparam logic [3:0] HLAST = 4'(HOLD - 1);
    typedef enum logic [2:0] {IDLE, ADDR, GAP1, XFER, GAP2} state_t;
    state_t        st, st_n;
    logic [12:0]   mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   fcnt;
    logic [12:0]   head;
    logic          push, pop;
    logic [3:0]    hc, hc_n;
    logic          cur_rd, cur_rd_n;
    logic [7:0]    cur_data, cur_data_n, dout_n, rdd_n;
    logic          bdir_n, bc1_n, rdv_n;

    assign cmd_ready = !fcnt[AW];
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rp];
    assign busy      = fcnt != '0 || st != IDLE;

    // FIFO storage; validity is tracked by fcnt, so contents need no reset
    always_ff @(posedge clk)
        if (push) mem[wp] <= {cmd_rd, cmd_addr, cmd_data};

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (push != pop) fcnt <= push ? fcnt + (AW+1)'(1) : fcnt - (AW+1)'(1);
        end
    end

    // State, hold counter, latched command and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            hc       <= '0;
            cur_rd   <= 1'b0;
            cur_data <= '0;
            bdir     <= 1'b0;
            bc1      <= 1'b0;
            bus_dout <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            st       <= st_n;
            hc       <= hc_n;
            cur_rd   <= cur_rd_n;
            cur_data <= cur_data_n;
            bdir     <= bdir_n;
            bc1      <= bc1_n;
            bus_dout <= dout_n;
            rd_valid <= rdv_n;
            rd_data  <= rdd_n;
        end
    end

    // Next state and next bus outputs, so outputs change on the same edge as the state
    always_comb begin
        st_n       = st;
        hc_n       = hc;
        cur_rd_n   = cur_rd;
        cur_data_n = cur_data;
        bdir_n     = 1'b0;
        bc1_n      = 1'b0;
        dout_n     = bus_dout;
        rdd_n      = rd_data;
        rdv_n      = 1'b0;
        pop        = 1'b0;
        case (st)
            IDLE: if (fcnt != '0) begin
                pop        = 1'b1;
                st_n       = ADDR;
                hc_n       = HLAST;
                cur_rd_n   = head[12];
                cur_data_n = head[7:0];
                bdir_n     = 1'b1;
                bc1_n      = 1'b1;
                dout_n     = {4'h0, head[11:8]};
            end
            ADDR: if (hc == '0) st_n = GAP1;
                else begin
                    hc_n   = hc - 4'd1;
                    bdir_n = 1'b1;
                    bc1_n  = 1'b1;
                end
            GAP1: begin
                st_n   = XFER;
                hc_n   = HLAST;
                bdir_n = !cur_rd;
                bc1_n  = cur_rd;
                dout_n = cur_rd ? 8'h00 : cur_data;
            end
            XFER: if (hc == '0) begin
                    st_n  = GAP2;
                    rdv_n = cur_rd;
                    rdd_n = cur_rd ? bus_din : rd_data;
                end else begin
                    hc_n   = hc - 4'd1;
                    bdir_n = !cur_rd;
                    bc1_n  = cur_rd;
                end
            GAP2: st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_jt49_bus_seq.sv
// tb_jt49_bus_seq: directed vectors for jt49_bus_seq at HOLD=2 and HOLD=5
module tb_jt49_bus_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v2 = 1'b0, r2 = 1'b0;
    logic [3:0] a2 = '0;
    logic [7:0] d2 = '0;
    logic       rdy2, rdv2, busy2, bdir2, bc12;
    logic [7:0] rdd2, dout2, din2;
    logic       v5 = 1'b0, r5 = 1'b0;
    logic [3:0] a5 = '0;
    logic [7:0] d5 = '0;
    logic       rdy5, rdv5, busy5, bdir5, bc15;
    logic [7:0] rdd5, dout5, din5;

    // PSG models: answer a fixed byte while the bus is in the read phase
    assign din2 = (!bdir2 && bc12) ? 8'hA5 : 8'h5A;
    assign din5 = (!bdir5 && bc15) ? 8'h3C : 8'hC3;

    jt49_bus_seq #(.AW(2), .HOLD(2)) u2 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_rd(r2),
        .cmd_addr(a2), .cmd_data(d2), .rd_valid(rdv2), .rd_data(rdd2), .busy(busy2),
        .bdir(bdir2), .bc1(bc12), .bus_dout(dout2), .bus_din(din2));

    jt49_bus_seq #(.AW(2), .HOLD(5)) u5 (
        .clk(clk), .rst(rst), .cmd_valid(v5), .cmd_ready(rdy5), .cmd_rd(r5),
        .cmd_addr(a5), .cmd_data(d5), .rd_valid(rdv5), .rd_data(rdd5), .busy(busy5),
        .bdir(bdir5), .bc1(bc15), .bus_dout(dout5), .bus_din(din5));

    int n_cmp = 0, n_err = 0;

    task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       v, rd;
        logic [3:0] a;
        logic [7:0] d;
        logic [1:0] bb;
        logic [7:0] dout;
        logic       dc, rdv, busy;
        logic [7:0] rdd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic rd, input logic [3:0] a, input logic [7:0] d,
                                input logic [1:0] bb, input logic [7:0] dout, input logic dc,
                                input logic rdv, input logic busy, input logic [7:0] rdd);
        vec_t t;
        t.v = v; t.rd = rd; t.a = a; t.d = d; t.bb = bb; t.dout = dout;
        t.dc = dc; t.rdv = rdv; t.busy = busy; t.rdd = rdd;
        return t;
    endfunction

    // Bus-sequence monitor for the HOLD=2 instance
    int cyc = 0;
    logic mon = 1'b0;
    logic [1:0] prev_bb = 2'b00;
    int q_st[$];
    logic [7:0] q_a[$], q_d[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mon) begin
            if ({bdir2, bc12} == 2'b11 && prev_bb != 2'b11) begin
                q_st.push_back(cyc);
                q_a.push_back(dout2);
            end
            if ({bdir2, bc12} == 2'b10 && prev_bb != 2'b10) q_d.push_back(dout2);
        end
        prev_bb = {bdir2, bc12};
    end

    function automatic logic [1:0] exp5_bb(input int c);
        if (c >= 2 && c <= 6) return 2'b11;
        if (c >= 8 && c <= 12) return 2'b10;
        if (c >= 15 && c <= 19) return 2'b11;
        if (c >= 21 && c <= 25) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] exp5_dout(input int c);
        if (c >= 2 && c <= 6) return 8'h09;
        if (c >= 8 && c <= 12) return 8'hE1;
        if (c >= 15 && c <= 19) return 8'h04;
        return 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t tbl[19];
    int exp_acc[6] = '{0, 1, 2, 3, 4, 9};
    int acc_c[6] = '{-1, -1, -1, -1, -1, -1};

    initial begin
        tbl[0]  = mk(1, 0, 4'h7, 8'h38, 2'b00, 8'h00, 1, 0, 0, 8'h00);
        tbl[1]  = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 1, 8'h00);
        tbl[2]  = mk(0, 0, 4'h0, 8'h00, 2'b11, 8'h07, 1, 0, 1, 8'h00);
        tbl[3]  = mk(0, 0, 4'h0, 8'h00, 2'b11, 8'h07, 1, 0, 1, 8'h00);
        tbl[4]  = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h07, 1, 0, 1, 8'h00);
        tbl[5]  = mk(0, 0, 4'h0, 8'h00, 2'b10, 8'h38, 1, 0, 1, 8'h00);
        tbl[6]  = mk(0, 0, 4'h0, 8'h00, 2'b10, 8'h38, 1, 0, 1, 8'h00);
        tbl[7]  = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 1, 8'h00);
        tbl[8]  = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 0, 8'h00);
        tbl[9]  = mk(1, 1, 4'h3, 8'h99, 2'b00, 8'h00, 0, 0, 0, 8'h00);
        tbl[10] = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 1, 8'h00);
        tbl[11] = mk(0, 0, 4'h0, 8'h00, 2'b11, 8'h03, 1, 0, 1, 8'h00);
        tbl[12] = mk(0, 0, 4'h0, 8'h00, 2'b11, 8'h03, 1, 0, 1, 8'h00);
        tbl[13] = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h03, 1, 0, 1, 8'h00);
        tbl[14] = mk(0, 0, 4'h0, 8'h00, 2'b01, 8'h00, 1, 0, 1, 8'h00);
        tbl[15] = mk(0, 0, 4'h0, 8'h00, 2'b01, 8'h00, 1, 0, 1, 8'h00);
        tbl[16] = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 1, 1, 8'hA5);
        tbl[17] = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 0, 8'hA5);
        tbl[18] = mk(0, 0, 4'h0, 8'h00, 2'b00, 8'h00, 0, 0, 0, 8'hA5);

        // Reset held for 3 cycles, then 3 idle cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_bb", i, {6'b0, bdir2, bc12}, 8'h00);
            check("rst_dout", i, dout2, 8'h00);
            check("rst_busy", i, {7'b0, busy2}, 8'h00);
            check("rst_ready", i, {7'b0, rdy2}, 8'h01);
            check("rst_rdv", i, {7'b0, rdv2}, 8'h00);
            check("rst_rdd", i, rdd2, 8'h00);
            if (i == 2) rst = 1'b0;
        end

        // Single write then single read, HOLD=2
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("tbl_bb", i, {6'b0, bdir2, bc12}, {6'b0, tbl[i].bb});
            if (tbl[i].dc) check("tbl_dout", i, dout2, tbl[i].dout);
            check("tbl_rdv", i, {7'b0, rdv2}, {7'b0, tbl[i].rdv});
            check("tbl_busy", i, {7'b0, busy2}, {7'b0, tbl[i].busy});
            check("tbl_rdd", i, rdd2, tbl[i].rdd);
            check("tbl_ready", i, {7'b0, rdy2}, 8'h01);
            v2 = tbl[i].v; r2 = tbl[i].rd; a2 = tbl[i].a; d2 = tbl[i].d;
        end

        // FIFO full: six writes with cmd_valid held high
        mon = 1'b1;
        begin
            int k, c;
            logic ok;
            k = 0; c = 0;
            while (k < 6 && c < 60) begin
                @(negedge clk);
                v2 = 1'b1; r2 = 1'b0; a2 = 4'(k); d2 = 8'h10 + 8'(k);
                ok = rdy2;
                @(posedge clk);
                if (ok) begin
                    acc_c[k] = c;
                    k++;
                end
                c++;
            end
            @(negedge clk);
            v2 = 1'b0;
        end
        for (int i = 0; i < 6; i++) check("accept_cycle", i, 8'(acc_c[i]), 8'(exp_acc[i]));
        begin
            int w;
            w = 0;
            while (busy2 && w < 200) begin
                @(negedge clk);
                w++;
            end
        end
        check("drain_busy", 0, {7'b0, busy2}, 8'h00);
        mon = 1'b0;
        check("n_addr_seq", 0, 8'(q_a.size()), 8'd6);
        check("n_data_seq", 0, 8'(q_d.size()), 8'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q_a.size()) check("seq_addr", i, q_a[i], 8'(i));
            if (i < q_d.size()) check("seq_data", i, q_d[i], 8'h10 + 8'(i));
            if (i > 0 && i < q_st.size()) check("seq_space", i, 8'(q_st[i] - q_st[i-1]), 8'd7);
        end

        // Reset during the first XFER of a write followed by a queued read
        @(negedge clk); v2 = 1'b1; r2 = 1'b0; a2 = 4'h5; d2 = 8'h77;
        @(negedge clk); r2 = 1'b1; a2 = 4'h6;
        @(negedge clk); v2 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_xfer_bb", 0, {6'b0, bdir2, bc12}, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bb", 0, {6'b0, bdir2, bc12}, 8'h00);
        check("mid_rst_busy", 0, {7'b0, busy2}, 8'h00);
        check("mid_rst_ready", 0, {7'b0, rdy2}, 8'h01);
        check("mid_rst_rdv", 0, {7'b0, rdv2}, 8'h00);
        rst = 1'b0;
        begin
            int act;
            act = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bdir2 || bc12 || rdv2 || busy2) act++;
            end
            check("post_rst_activity", 0, 8'(act), 8'd0);
        end

        // HOLD=5: write then read, 13 cycles per command
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            check("h5_bb", c, {6'b0, bdir5, bc15}, {6'b0, exp5_bb(c)});
            if (exp5_bb(c) != 2'b00) check("h5_dout", c, dout5, exp5_dout(c));
            check("h5_rdv", c, {7'b0, rdv5}, {7'b0, c == 26});
            check("h5_busy", c, {7'b0, busy5}, {7'b0, c >= 1 && c <= 26});
            check("h5_rdd", c, rdd5, c >= 26 ? 8'h3C : 8'h00);
            v5 = c < 2;
            r5 = c == 1;
            a5 = c == 0 ? 4'h9 : 4'h4;
            d5 = c == 0 ? 8'hE1 : 8'h00;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
